stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_pkg.sv | 34 +++
 rtl/stream_rr_arbiter_skid.sv | 45 ++++
 rtl/stream_rr_arbiter.sv | 94 +++++++++
 tb/tb_stream_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared bus utilities for the stream round-robin arbiter: FSM encoding and
// round-robin search helpers sized for up to 16 requesters.
package stream_rr_arbiter_pkg;

  localparam int unsigned MaxInputs   = 16;
  localparam int unsigned MaxSrcWidth = 4;

  typedef enum logic [0:0] {StIdle, StLocked} arb_state_e;

  // First set bit of req at or above ptr, wrapping within num requesters.
  function automatic logic [MaxSrcWidth-1:0] rr_search(input logic [MaxInputs-1:0]   req,
                                                        input logic [MaxSrcWidth-1:0] ptr,
                                                        input int unsigned            num);
    logic [MaxSrcWidth-1:0] sel;
    logic                   found;
    int unsigned            idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxInputs; i++) begin
      idx = (int'(ptr) + i) % num;
      if ((i < num) && !found && req[idx[MaxSrcWidth-1:0]]) begin
        sel   = idx[MaxSrcWidth-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [MaxSrcWidth-1:0] rr_next(input logic [MaxSrcWidth-1:0] ptr,
                                                      input int unsigned            num);
    return (int'(ptr) + 1 == num) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_skid.sv
// Two-entry skid stage: registered ready that only drops when both slots hold data.
module stream_rr_arbiter_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             push, pop;

  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: holds a grant until the last beat of a
// packet transfers, then rotates priority past the winner.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SRC_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [SRC_WIDTH-1:0]             out_source,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int unsigned SbWidth = DATA_WIDTH + 1 + SRC_WIDTH;

  arb_state_e           state_q, state_d;
  logic [SRC_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [SRC_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                  gnt_valid, gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  sb_in_valid, sb_in_ready;
  logic [SbWidth-1:0]    sb_in_data, sb_out_data;

  always_comb begin
    gnt_valid  = in_valid[grant_idx_q];
    gnt_last   = in_last[grant_idx_q];
    gnt_data   = in_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    sb_in_data = {gnt_last, grant_idx_q, gnt_data};
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    in_ready    = '0;
    sb_in_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|in_valid) begin
          grant_idx_d = SRC_WIDTH'(rr_search(MaxInputs'(in_valid), MaxSrcWidth'(rr_ptr_q),
                                             NUM_INPUTS));
          state_d     = StLocked;
        end
      end
      StLocked: begin
        in_ready[grant_idx_q] = sb_in_ready;
        sb_in_valid           = gnt_valid;
        // Release on the last beat even if the skid stage is about to fill.
        if (gnt_valid && sb_in_ready && gnt_last) begin
          state_d  = StIdle;
          rr_ptr_d = SRC_WIDTH'(rr_next(MaxSrcWidth'(grant_idx_q), NUM_INPUTS));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  stream_rr_arbiter_skid #(
    .WIDTH (SbWidth)
  ) skid_buffer (
    .clk       (clk),
    .reset     (reset),
    .in_data   (sb_in_data),
    .in_valid  (sb_in_valid),
    .in_ready  (sb_in_ready),
    .out_data  (sb_out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {out_last, out_source, out_data} = sb_out_data;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and randomized bench for stream_rr_arbiter; a transaction-level model
// predicts grant order and the output beat stream.
module tb_stream_rr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NI = 4;
  localparam int unsigned SW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_last, in_valid, in_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [SW-1:0]    out_source;
  logic             out_valid, out_ready;

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .SRC_WIDTH  (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_source (out_source),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [DW-1:0] data; logic last; logic [SW-1:0] src;} obeat_t;

  beat_t   src_q [NI][$];
  obeat_t  exp_q[$];
  obeat_t  out_log[$];
  int      out_cyc[$];
  int      grant_log[$];
  logic [NI-1:0] in_x, stall, in_pkt, rdy_s;
  int      xfer_cnt[NI];
  int      model_ptr;
  int      checks   = 0;
  int      failures = 0;
  int      cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule at packet level: first pending requester at/after model_ptr.
  function automatic int rr_pick();
    for (int k = 0; k < NI; k++) begin
      int idx;
      idx = (model_ptr + k) % NI;
      if (src_q[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  task automatic load_pkt(input int src, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) src_q[src].push_back({base + DW'(b), b == len - 1});
  endtask

  // Present the next beat on idle requesters; a held valid is never withdrawn.
  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (!in_valid[i] && src_q[i].size() > 0 && !(stall[i] && in_pkt[i])) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = src_q[i][0].data;
        in_last[i]           = src_q[i][0].last;
      end
    end
  endtask

  task automatic cycle();
    obeat_t e;
    int     exp_src;
    @(negedge clk);
    cyc++;
    rdy_s = in_ready;
    in_x  = in_valid & in_ready;
    chk("ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
    if (out_valid && out_ready) begin
      out_cyc.push_back(cyc);
      out_log.push_back({out_data, out_last, out_source});
      if (exp_q.size() == 0) begin
        chk("out_spurious", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", 32'(out_last), 32'(e.last));
        chk("out_source", 32'(out_source), 32'(e.src));
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (in_x[i]) begin
        if (!in_pkt[i]) begin
          exp_src = rr_pick();
          chk("rr_grant", i, exp_src);
          grant_log.push_back(i);
        end
        chk("no_interleave", 32'(in_pkt & ~(NI'(1) << i)), 32'd0);
        exp_q.push_back({src_q[i][0].data, src_q[i][0].last, SW'(i)});
        in_pkt[i] = !src_q[i][0].last;
        if (src_q[i][0].last) model_ptr = (i + 1) % NI;
        xfer_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (in_x[i]) begin
        src_q[i].delete(0);
        in_valid[i] = 1'b0;
      end
    end
    in_x = '0;
    drive();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    in_x      = '0;
    stall     = '0;
    in_pkt    = '0;
    model_ptr = 0;
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      xfer_cnt[i] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    out_log.delete();
    out_cyc.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    cyc++;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int exp_order[6];
    logic done;
    exp_order = '{0, 1, 3, 0, 1, 3};
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    do_reset();

    // Single requester, 3-beat packet.
    load_pkt(2, 3, 32'hA);
    drive();
    t0 = cyc + 1;
    cycle();
    chk("arb_cycle_ready", 32'(rdy_s), 32'd0);
    cycle();
    chk("locked_ready", 32'(rdy_s), 32'b0100);
    for (int n = 0; n < 20 && out_log.size() < 3; n++) cycle();
    chk("single_beats", out_log.size(), 3);
    if (out_log.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("single_cycle", out_cyc[k], t0 + 2 + k);
        chk("single_data", out_log[k].data, 32'hA + k);
        chk("single_last", 32'(out_log[k].last), 32'(k == 2));
        chk("single_src", 32'(out_log[k].src), 32'd2);
      end
    end

    // Round-robin among 0,1,3 with continuous demand.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      load_pkt(0, 1, 32'h100 + p);
      load_pkt(1, 1, 32'h110 + p);
      load_pkt(3, 1, 32'h130 + p);
    end
    drive();
    for (int n = 0; n < 40 && grant_log.size() < 6; n++) cycle();
    chk("rr_count", grant_log.size(), 6);
    if (grant_log.size() == 6)
      for (int k = 0; k < 6; k++) chk("rr_order", grant_log[k], exp_order[k]);

    // Backpressure on a 4-beat packet.
    do_reset();
    out_ready = 1'b0;
    load_pkt(1, 4, 32'h10);
    drive();
    repeat (8) cycle();
    chk("bp_accepted", xfer_cnt[1], 2);
    chk("bp_ready_low", 32'(rdy_s[1]), 32'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_log.size() < 4; n++) cycle();
    chk("bp_beats", out_log.size(), 4);
    if (out_log.size() == 4)
      for (int k = 0; k < 4; k++) chk("bp_data", out_log[k].data, 32'h10 + k);
    chk("bp_exp_empty", exp_q.size(), 0);

    // No interleave while the granted requester stalls mid-packet.
    do_reset();
    stall[0] = 1'b1;
    load_pkt(0, 4, 32'h20);
    load_pkt(3, 1, 32'h30);
    drive();
    for (int n = 0; n < 10 && !in_pkt[0]; n++) cycle();
    chk("ni_started", 32'(in_pkt[0]), 32'd1);
    repeat (5) begin
      cycle();
      chk("ni_stall_ready3", 32'(rdy_s[3]), 32'd0);
    end
    stall[0] = 1'b0;
    drive();
    for (int n = 0; n < 20 && src_q[0].size() > 0; n++) begin
      cycle();
      chk("ni_ready3", 32'(rdy_s[3]), 32'd0);
    end
    for (int n = 0; n < 20 && src_q[3].size() > 0; n++) cycle();
    chk("ni_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("ni_first", grant_log[0], 0);
      chk("ni_second", grant_log[1], 3);
    end

    // Reset in the middle of a packet.
    do_reset();
    load_pkt(2, 4, 32'h40);
    drive();
    for (int n = 0; n < 10 && xfer_cnt[2] < 2; n++) cycle();
    chk("mid_accepted", xfer_cnt[2], 2);
    do_reset();
    load_pkt(2, 1, 32'h50);
    load_pkt(0, 1, 32'h60);
    drive();
    for (int n = 0; n < 10 && grant_log.size() < 1; n++) cycle();
    chk("mid_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    for (int n = 0; n < 20 && (exp_q.size() > 0 || src_q[2].size() > 0); n++) cycle();

    // Randomized packets, stalls and backpressure.
    do_reset();
    for (int i = 0; i < NI; i++) begin
      int np;
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) load_pkt(i, int'($urandom_range(1, 4)), DW'($urandom));
    end
    drive();
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NI; i++) stall[i] = ($urandom_range(0, 3) == 0);
      cycle();
      done = 1'b1;
      for (int i = 0; i < NI; i++) if (src_q[i].size() > 0) done = 1'b0;
      if (exp_q.size() > 0) done = 1'b0;
    end
    chk("rand_drain", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
